// File: rtl/onehot_decoder.sv
// Sequential 3-to-8 one-hot decoder: codes are queued in a small FIFO and replayed
// as HOLD-cycle one-hot strobes on d, each followed by a single all-zero gap cycle.
module onehot_decoder #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               code,
  input  logic                     code_valid,
  output logic                     code_ready,
  input  logic                     en,
  output logic [7:0]               d,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FILL_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [7:0]    HOLD_LAST = 8'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } state_t;

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'd1 << idx;
  endfunction

  logic [2:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   fill_r;
  state_t        state_r;
  state_t        state_s;
  logic [7:0]    hold_r;
  logic [7:0]    hold_s;
  logic [7:0]    d_r;
  logic [7:0]    d_s;
  logic          push_s;
  logic          pop_s;

  assign code_ready = (fill_r != FILL_FULL);
  assign push_s     = code_valid && code_ready;
  // Pop only from IDLE while unblanked; a code written on this edge is never seen here.
  assign pop_s      = !en && (state_r == IDLE) && (fill_r != FILL_ZERO);

  assign d    = d_r & {8{~en}};
  assign fill = fill_r;
  assign busy = (fill_r != FILL_ZERO) || (state_r != IDLE);

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= 3'd0;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      fill_r   <= FILL_ZERO;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= code;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Replay FSM next-state logic; blanking freezes state, count and strobe.
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    d_s     = d_r;
    if (en) begin
      state_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            d_s     = onehot(mem_r[rd_ptr_r]);
            hold_s  = HOLD_LAST;
            state_s = STROBE;
          end else begin
            d_s = 8'h00;
          end
        end
        STROBE: begin
          if (hold_r == 8'd0) begin
            d_s     = 8'h00;
            state_s = GAP;
          end else begin
            hold_s = hold_r - 8'd1;
          end
        end
        GAP: begin
          d_s     = 8'h00;
          state_s = IDLE;
        end
        default: begin
          d_s     = 8'h00;
          hold_s  = 8'd0;
          state_s = IDLE;
        end
      endcase
    end
  end

  // Replay FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      hold_r  <= 8'd0;
      d_r     <= 8'h00;
    end else begin
      state_r <= state_s;
      hold_r  <= hold_s;
      d_r     <= d_s;
    end
  end

endmodule

// File: tb/tb_onehot_decoder.sv
// Bench for onehot_decoder: table-driven reset/latency vectors, directed corner
// sequences and random traffic checked against a slot-timing reference model.
module tb_onehot_decoder;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] code = 3'd0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic       en = 1'b0;
  logic [7:0] d;
  logic [2:0] fill;
  logic       busy;

  onehot_decoder #(.HOLD(HOLD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .code_valid(code_valid),
    .code_ready(code_ready), .en(en), .d(d), .fill(fill), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: queue of codes plus the elapsed position inside the current
  // slot (HOLD strobe cycles then one gap cycle); no active slot means idle.
  int m_q[$];
  bit m_act;
  int m_t;
  int m_code;

  logic [7:0] prev_d;
  logic [7:0] strobes[$];
  int asserted_cnt;
  int max_fill;

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       e;
    logic [7:0] xd;
    int         xfill;
    logic       xrdy;
    logic       xbusy;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_d(input logic e);
    logic [7:0] one;
    one = 8'd1;
    if (m_act && m_t < HOLD && !e) return one << m_code;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_act = 1'b0;
    m_t = 0;
    m_code = 0;
  endtask

  task automatic model_edge(input logic v, input logic [2:0] c, input logic e);
    bit do_pop;
    bit do_push;
    do_pop  = !m_act && m_q.size() > 0 && !e;
    do_push = v && m_q.size() < DEPTH;
    if (!e && m_act) begin
      m_t++;
      if (m_t == HOLD + 1) m_act = 1'b0;
    end
    if (do_pop) begin
      m_code = m_q.pop_front();
      m_act = 1'b1;
      m_t = 0;
    end
    if (do_push) m_q.push_back(int'(c));
  endtask

  // Called at a falling edge: drive inputs, then compare outputs to the model.
  task automatic drive(input logic v, input logic [2:0] c, input logic e);
    code_valid = v;
    code = c;
    en = e;
    #1;
    check("d", d, model_d(e));
    check("fill", fill, m_q.size());
    check("code_ready", code_ready, m_q.size() < DEPTH);
    check("busy", busy, (m_q.size() != 0) || m_act);
    if (d != 8'h00 && prev_d == 8'h00) strobes.push_back(d);
    if (d != 8'h00) asserted_cnt++;
    if (int'(fill) > max_fill) max_fill = int'(fill);
    prev_d = d;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge(code_valid, code, en);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 3'd0, 1'b0);
      advance();
    end
  endtask

  initial begin
    logic [7:0] one;
    int idx;
    int budget;
    logic rdy;
    one = 8'd1;
    prev_d = 8'h00;
    asserted_cnt = 0;
    max_fill = 0;
    model_reset();

    // Single push of code 5 straight out of reset.
    tbl[0] = '{1'b1, 3'd5, 1'b0, 8'h00, 0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 3'd0, 1'b0, 8'h00, 1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 3'd0, 1'b0, 8'h20, 0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 3'd0, 1'b0, 8'h20, 0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 3'd0, 1'b0, 8'h20, 0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 3'd0, 1'b0, 8'h20, 0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 3'd0, 1'b0, 8'h00, 0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 3'd0, 1'b0, 8'h00, 0, 1'b1, 1'b0};

    @(negedge clk);
    @(negedge clk);
    check("reset_d", d, 8'h00);
    check("reset_fill", fill, 3'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", code_ready, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].e);
      check("tbl_d", d, tbl[i].xd);
      check("tbl_fill", fill, tbl[i].xfill);
      check("tbl_ready", code_ready, tbl[i].xrdy);
      check("tbl_busy", busy, tbl[i].xbusy);
      advance();
    end

    // Sweep of all codes, handshaking on ready.
    strobes.delete();
    max_fill = 0;
    idx = 0;
    budget = 200;
    while (idx < 8 && budget > 0) begin
      drive(1'b1, 3'(idx), 1'b0);
      rdy = code_ready;
      advance();
      if (rdy) idx++;
      budget--;
    end
    check("sweep_all_pushed", idx, 8);
    idle_cycles(60);
    check("sweep_count", strobes.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < strobes.size()) check("sweep_order", strobes[i], one << i);
    end
    check("sweep_fill_max", max_fill <= DEPTH, 1'b1);

    // Overflow while blanked: only the first DEPTH codes survive.
    strobes.delete();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 3'((k + 3) % 8), 1'b1);
      advance();
    end
    drive(1'b0, 3'd0, 1'b1);
    check("ovf_fill", fill, 3'd4);
    check("ovf_ready", code_ready, 1'b0);
    check("ovf_d_blank", d, 8'h00);
    advance();
    idle_cycles(30);
    check("ovf_count", strobes.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < strobes.size()) check("ovf_order", strobes[i], one << (i + 3));
    end

    // Blanking during the second strobe cycle of code 2.
    asserted_cnt = 0;
    drive(1'b1, 3'd2, 1'b0); advance();
    drive(1'b0, 3'd0, 1'b0); advance();
    drive(1'b0, 3'd0, 1'b0);
    check("blank_first", d, 8'h04);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd0, 1'b1);
      check("blank_masked", d, 8'h00);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd0, 1'b0);
      check("blank_resume", d, 8'h04);
      advance();
    end
    drive(1'b0, 3'd0, 1'b0);
    check("blank_gap", d, 8'h00);
    advance();
    check("blank_total", asserted_cnt, 4);
    idle_cycles(3);

    // Simultaneous push and pop at fill 2.
    strobes.delete();
    drive(1'b1, 3'd6, 1'b1); advance();
    drive(1'b1, 3'd1, 1'b1); advance();
    drive(1'b1, 3'd7, 1'b0);
    check("pp_fill_before", fill, 3'd2);
    advance();
    drive(1'b0, 3'd0, 1'b0);
    check("pp_fill_after", fill, 3'd2);
    advance();
    idle_cycles(25);
    check("pp_count", strobes.size(), 3);
    if (strobes.size() == 3) begin
      check("pp_order0", strobes[0], 8'h40);
      check("pp_order1", strobes[1], 8'h02);
      check("pp_order2", strobes[2], 8'h80);
    end

    // Asynchronous reset in the middle of a strobe with codes queued.
    drive(1'b1, 3'd5, 1'b0); advance();
    drive(1'b1, 3'd3, 1'b0); advance();
    drive(1'b0, 3'd0, 1'b0);
    check("rst_pre_d", d, 8'h20);
    code_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_d", d, 8'h00);
    check("rst_async_fill", fill, 3'd0);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_ready", code_ready, 1'b1);
    model_reset();
    prev_d = 8'h00;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    strobes.delete();
    idle_cycles(20);
    check("rst_no_replay", strobes.size(), 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 4) == 0);
      advance();
    end
    idle_cycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
